// File: rtl/text_entry_buffer.sv
// rtl/text_entry_buffer.sv - debounced push-button text entry buffer with circular character storage (optional TEXT_ENTRY_SCROLL_EN)
module text_entry_buffer #(
    parameter int CHAR_W    = 8,
    parameter int DEPTH     = 32,
    parameter int DB_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       btn_commit,
    input  logic                       btn_back,
    input  logic                       btn_clear,
    input  logic [CHAR_W-1:0]          char_in,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [CHAR_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic [CHAR_W-1:0]          last_char
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Button lanes: bit 0 commit, bit 1 back, bit 2 clear
    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    pulse_q, pulse_d;
    logic [CW-1:0] db_cnt_q [3];
    logic [CW-1:0] db_cnt_d [3];

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [CHAR_W-1:0] last_char_q, last_char_d;
    logic [CHAR_W-1:0] rd_data_q, rd_data_d;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW:0]       last_idx;
    logic              do_clear, do_back, do_commit;

    assign btn_raw = {btn_clear, btn_back, btn_commit};

    // Synchronise, debounce and edge-detect each button; any agreement restarts the count
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end
        end
        pulse_d = stable_d & ~stable_q;
    end

    // Resolve commands (clear > back > commit) and compute next buffer state
    always_comb begin
        do_clear    = pulse_q[2];
        do_back     = pulse_q[1] & ~pulse_q[2];
        do_commit   = pulse_q[0] & ~pulse_q[1] & ~pulse_q[2];
        head_d      = head_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = head_q + count_q[AW-1:0];
        if (do_clear) begin
            head_d  = '0;
            count_d = '0;
        end else if (do_back) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_ONE;
            end
        end else if (do_commit) begin
            if (count_q != DEPTH_C) begin
                wr_en   = 1'b1;
                count_d = count_q + CNT_ONE;
            end else begin
                overflow_d = 1'b1;
`ifdef TEXT_ENTRY_SCROLL_EN
                // Full buffer: the write slot is the oldest entry, which the head then skips past
                wr_en  = 1'b1;
                head_d = head_q + PTR_ONE;
`endif
            end
        end

        last_idx = count_d - CNT_ONE;
        if (count_d == '0) begin
            last_char_d = '0;
        end else if (wr_en) begin
            last_char_d = char_in;
        end else begin
            last_char_d = mem[head_d + last_idx[AW-1:0]];
        end

        if ({1'b0, rd_addr} < count_q) begin
            rd_data_d = mem[head_q + rd_addr];
        end else begin
            rd_data_d = '0;
        end
    end

    // Button pipeline state, cleared asynchronously so a pending press is forgotten
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Buffer bookkeeping and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            last_char_q <= '0;
            rd_data_q   <= '0;
        end else begin
            head_q      <= head_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            last_char_q <= last_char_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Character storage; contents survive reset and clear since count gates every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= char_in;
        end
    end

    assign rd_data   = rd_data_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign overflow  = overflow_q;
    assign last_char = last_char_q;

endmodule

// File: tb/tb_text_entry_buffer.sv
// tb/tb_text_entry_buffer.sv - directed and randomized checks of text_entry_buffer against a queue model
module tb_text_entry_buffer;

    localparam int CHAR_W = 8;
    localparam int DEPTH  = 4;
    localparam int DB     = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              btn_commit, btn_back, btn_clear;
    logic [CHAR_W-1:0] char_in;
    logic [1:0]        rd_addr;
    logic [CHAR_W-1:0] rd_data;
    logic [2:0]        count;
    logic              empty, full, overflow;
    logic [CHAR_W-1:0] last_char;

    int errors = 0;
    int checks = 0;
    int ovf_seen = 0;
    int ovf_exp = 0;
    logic [7:0] q[$];

    text_entry_buffer #(.CHAR_W(CHAR_W), .DEPTH(DEPTH), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_commit(btn_commit), .btn_back(btn_back), .btn_clear(btn_clear),
        .char_in(char_in), .rd_addr(rd_addr), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full), .overflow(overflow),
        .last_char(last_char)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: buffer is an ordered list, oldest first
    task automatic m_commit(input logic [7:0] c);
        if (q.size() < DEPTH) begin
            q.push_back(c);
        end else begin
            ovf_exp++;
`ifdef TEXT_ENTRY_SCROLL_EN
            void'(q.pop_front());
            q.push_back(c);
`endif
        end
    endtask

    task automatic m_back();
        if (q.size() > 0) void'(q.pop_back());
    endtask

    task automatic m_clear();
        q.delete();
    endtask

    task automatic press(input int b, input logic [7:0] c);
        char_in = c;
        case (b)
            0: btn_commit = 1'b1;
            1: btn_back = 1'b1;
            default: btn_clear = 1'b1;
        endcase
        tick(10);
        btn_commit = 1'b0;
        btn_back = 1'b0;
        btn_clear = 1'b0;
        tick(10);
        case (b)
            0: m_commit(c);
            1: m_back();
            default: m_clear();
        endcase
    endtask

    task automatic check_state(input string tag);
        logic [7:0] lc;
        lc = (q.size() > 0) ? q[q.size()-1] : 8'h00;
        chk({tag, ".count"}, count, q.size());
        chk({tag, ".last_char"}, last_char, lc);
        chk({tag, ".empty"}, empty, q.size() == 0);
        chk({tag, ".full"}, full, q.size() == DEPTH);
        chk({tag, ".overflow_pulses"}, ovf_seen, ovf_exp);
    endtask

    task automatic check_reads(input string tag);
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = 2'(i);
            @(posedge clk);
            @(negedge clk);
            exp = (i < q.size()) ? q[i] : 8'h00;
            chk($sformatf("%s.rd%0d", tag, i), rd_data, exp);
        end
        tick(1);
    endtask

    initial begin
        reset_n = 1'b0;
        btn_commit = 1'b0;
        btn_back = 1'b0;
        btn_clear = 1'b0;
        char_in = '0;
        rd_addr = '0;
        tick(3);
        chk("rst.count", count, 0);
        chk("rst.empty", empty, 1);
        chk("rst.full", full, 0);
        chk("rst.last_char", last_char, 0);
        chk("rst.rd_data", rd_data, 0);
        chk("rst.overflow", overflow, 0);
        reset_n = 1'b1;
        tick(2);

        // Three clean commits and readback, including an out-of-range index
        press(0, 8'h41);
        press(0, 8'h42);
        press(0, 8'h43);
        check_state("abc");
        check_reads("abc");

        // Fill, then one more commit when full
        press(2, 8'h00);
        for (int i = 0; i < DEPTH; i++) press(0, 8'(8'h31 + i));
        check_state("fill");
        press(0, 8'h35);
        check_state("ovf");
        check_reads("ovf");

        // Back to empty and one more back
        press(2, 8'h00);
        press(0, 8'h41);
        press(0, 8'h42);
        press(1, 8'h00);
        check_state("back1");
        press(1, 8'h00);
        check_state("back2");
        press(1, 8'h00);
        check_state("back3");

        // Bouncing contacts must not commit; a steady hold commits once
        char_in = 8'h77;
        for (int i = 0; i < 10; i++) begin
            btn_commit = 1'b1;
            tick(2);
            btn_commit = 1'b0;
            tick(2);
        end
        check_state("bounce");
        btn_commit = 1'b1;
        tick(10);
        btn_commit = 1'b0;
        tick(10);
        m_commit(8'h77);
        check_state("bounce_hold");

        // Clear and commit in the same cycle: clear wins
        press(2, 8'h00);
        press(0, 8'(($urandom % 255) + 1));
        press(0, 8'(($urandom % 255) + 1));
        char_in = 8'h99;
        btn_commit = 1'b1;
        btn_clear = 1'b1;
        tick(10);
        btn_commit = 1'b0;
        btn_clear = 1'b0;
        tick(10);
        m_clear();
        check_state("clr_vs_commit");

        // Randomized operation mix
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op == 0) press(2, 8'h00);
            else if (op <= 2) press(1, 8'h00);
            else press(0, 8'($urandom));
            check_state($sformatf("rnd%0d", n));
        end
        check_reads("rnd");

        // Reset in the middle of a debounce
        press(2, 8'h00);
        press(0, 8'h61);
        press(0, 8'h62);
        press(0, 8'h63);
        check_state("pre_rst");
        btn_commit = 1'b1;
        char_in = 8'h64;
        tick(4);
        #2 reset_n = 1'b0;
        #1;
        m_clear();
        chk("midrst.count", count, 0);
        chk("midrst.empty", empty, 1);
        chk("midrst.full", full, 0);
        chk("midrst.last_char", last_char, 0);
        chk("midrst.rd_data", rd_data, 0);
        chk("midrst.overflow", overflow, 0);
        btn_commit = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check_state("post_rst");

        // Button held across reset release counts as one fresh press
        reset_n = 1'b0;
        char_in = 8'h5a;
        btn_commit = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(30);
        m_commit(8'h5a);
        check_state("held_rst");
        btn_commit = 1'b0;
        tick(10);
        check_state("held_rel");
        check_reads("held");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_entry_buffer.md
TEXT_ENTRY_BUFFER -- requirements
Module: text_entry_buffer

Interface
REQ-001 SHALL have parameter CHAR_W, default 8, bit width of one character code.
REQ-002 SHALL have parameter DEPTH, default 32, number of character slots (power of two, >=2).
REQ-003 SHALL have parameter DB_CYCLES, default 1000000, cycles a raw button level must stay stable before it is accepted (10 ms at 100 MHz).
REQ-004 SHALL have port clk  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port btn_commit  input  1  raw, asynchronous push-button that appends char_in.
REQ-007 SHALL have port btn_back  input  1  raw, asynchronous push-button that deletes the newest character.
REQ-008 SHALL have port btn_clear  input  1  raw, asynchronous push-button that empties the buffer.
REQ-009 SHALL have port char_in  input  CHAR_W  character code from the switches.
REQ-010 SHALL have port rd_addr  input  log2(DEPTH)  logical read index (0 = oldest character), driven by the text renderer.
REQ-011 SHALL have port rd_data  output  CHAR_W  character at rd_addr.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  number of stored characters.
REQ-013 SHALL have ports empty, full, overflow, each output 1: count==0, count==DEPTH, and a one-cycle drop/overwrite pulse respectively.
REQ-014 SHALL have port last_char  output  CHAR_W  newest stored character, or 0 when empty.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser, then a debouncer whose stable level changes only after the synchronised level differs from it for DB_CYCLES consecutive cycles; any intermediate match restarts the counter.
REQ-016 A rising edge of a debounced level SHALL produce exactly one single-cycle internal pulse, issued 1 cycle after the stable level changes; held buttons SHALL NOT repeat.
REQ-017 Same-cycle pulses SHALL be resolved by priority clear > back > commit; lower-priority pulses in that cycle are discarded.
REQ-018 Commit with count<DEPTH SHALL store char_in at logical index count and increment count, visible the next cycle.
REQ-019 Back with count>0 SHALL decrement count; back with count==0 SHALL be a no-op without an overflow pulse.
REQ-020 Clear SHALL set count=0 and the oldest-entry pointer to 0; stored contents need not be erased.
REQ-021 rd_data SHALL be registered with 1-cycle latency: the value for rd_addr sampled at edge N appears after edge N; it SHALL be 0 when rd_addr>=count.
REQ-022 last_char SHALL equal the character at logical index count-1, or 0 when count==0, updated in the same cycle as count.
REQ-023 Storage SHALL be circular: physical address = (head + logical index) mod DEPTH, wrapping naturally at the power-of-two boundary.

Reset
REQ-024 Assertion of reset_n low SHALL immediately force count=0, head=0, rd_data=0, last_char=0, overflow=0, empty=1, full=0, all debounce counters and stable levels to 0, and synchroniser flops to 0.
REQ-025 A button held during reset release SHALL be treated as a new press once debounced (one pulse).
REQ-026 Reset asserted mid-debounce SHALL discard the pending press.

Configuration
REQ-027 Macro TEXT_ENTRY_SCROLL_EN SHALL select full-buffer behaviour.
REQ-028 Without TEXT_ENTRY_SCROLL_EN, commit when full SHALL discard char_in, leave state unchanged, and pulse overflow for 1 cycle.
REQ-029 With TEXT_ENTRY_SCROLL_EN, commit when full SHALL write char_in over the oldest entry, advance head by 1 (mod DEPTH), keep count=DEPTH, and pulse overflow for 1 cycle.

Verification (DEPTH=4, DB_CYCLES=4, CHAR_W=8)
REQ-030 Reset, then commit 0x41,0x42,0x43 as clean presses -> count=3, last_char=0x43, rd_addr=0..3 read 0x41,0x42,0x43,0x00 one cycle later.
REQ-031 Toggle btn_commit every 2 cycles for 20 cycles, then hold high 10 cycles -> exactly one commit, no commits during bouncing.
REQ-032 Fill with 0x31..0x34, commit 0x35 -> overflow one cycle; without macro contents 0x31..0x34; with macro contents 0x32..0x35, last_char=0x35, count=4.
REQ-033 Store 0x41,0x42, press back twice and a third time -> count 1 (last_char 0x41), then 0 (last_char 0, empty=1), third press no change, no overflow.
REQ-034 Debounced rising edges of btn_clear and btn_commit in the same cycle with count=2 -> count=0, char_in not stored.
REQ-035 Pull reset_n low mid-debounce with count=3 -> all outputs at reset values asynchronously, no commit after release.
